ir_nec_decoder: RTL and testbench

Front-end decoder for the IR receive path. It samples the demodulated IR receiver output and times the mark and space durations of NEC-format frames. It produces the read, done and error event pulses consumed by the downstream receive state machine, plus the decoded address and command bytes. Frame format: leader, 32 data bits, then a stop mark.

---
 rtl/ir_nec_decoder.sv | 199 +++++++++++++++++++
 tb/tb_ir_nec_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: times mark/space durations in half-unit ticks and emits
// read/done/error/repeat_code event pulses plus the last good address/command.
module ir_nec_decoder #(
    parameter int unsigned TICKS_PER_UNIT = 28125,
    parameter int unsigned TIMEOUT_HALF   = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ir_in,
    output logic       read,
    output logic       done,
    output logic       error,
    output logic       repeat_code,
    output logic [7:0] address,
    output logic [7:0] command,
    output logic       busy
);

    localparam int unsigned HALF = TICKS_PER_UNIT / 2;
    localparam int unsigned PW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(HALF - 1);
    localparam logic [7:0]    TIMEOUT   = (TIMEOUT_HALF > 255) ? 8'd255 : 8'(TIMEOUT_HALF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_REP_MARK,
        S_CHECK
    } state_t;

    state_t      state_q, state_d;
    logic        ir_s1_q, ir_s2_q, mark_q;
    logic [PW-1:0] presc_q;
    logic [7:0]  dur_q;
    logic [31:0] sr_q, sr_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        read_q, read_d, done_q, done_d;
    logic        error_q, error_d, rep_q, rep_d;
    logic [7:0]  addr_q, addr_d, cmd_q, cmd_d;

    logic mark, rise, fall, edge_any, timeout;

    function automatic logic in_win(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    assign mark     = ~ir_s2_q;
    assign rise     = mark & ~mark_q;
    assign fall     = ~mark & mark_q;
    assign edge_any = rise | fall;
    assign timeout  = dur_q > TIMEOUT;

    // Synchronizer flops reset to the idle-high level so reset release never fakes an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_s1_q <= 1'b1;
            ir_s2_q <= 1'b1;
            mark_q  <= 1'b0;
        end else begin
            ir_s1_q <= ir_in;
            ir_s2_q <= ir_s1_q;
            mark_q  <= mark;
        end
    end

    // dur counts completed half-units since the last mark edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            dur_q   <= '0;
        end else if (edge_any) begin
            presc_q <= '0;
            dur_q   <= '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
            if (dur_q != 8'd255) begin
                dur_q <= dur_q + 8'd1;
            end
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        read_d    = 1'b0;
        done_d    = 1'b0;
        error_d   = 1'b0;
        rep_d     = 1'b0;
        addr_d    = addr_q;
        cmd_d     = cmd_q;
        case (state_q)
            S_IDLE: begin
                if (rise) state_d = S_LEAD_MARK;
            end
            S_LEAD_MARK: begin
                if (fall) state_d = in_win(dur_q, 8'd28, 8'd36) ? S_LEAD_SPACE : S_IDLE;
            end
            S_LEAD_SPACE: begin
                if (timeout) begin
                    state_d = S_IDLE;
                end else if (rise) begin
                    if (in_win(dur_q, 8'd14, 8'd18)) begin
                        state_d   = S_BIT_MARK;
                        bit_cnt_d = '0;
                        read_d    = 1'b1;
                    end else if (in_win(dur_q, 8'd6, 8'd10)) begin
                        state_d = S_REP_MARK;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_BIT_MARK: begin
                if (timeout) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else if (fall) begin
                    if (in_win(dur_q, 8'd1, 8'd3)) begin
                        state_d = (bit_cnt_q == 6'd32) ? S_CHECK : S_BIT_SPACE;
                    end else begin
                        state_d = S_IDLE;
                        error_d = 1'b1;
                    end
                end
            end
            S_BIT_SPACE: begin
                if (timeout) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else if (rise) begin
                    if (in_win(dur_q, 8'd1, 8'd3) || in_win(dur_q, 8'd5, 8'd7)) begin
                        sr_d      = {in_win(dur_q, 8'd5, 8'd7), sr_q[31:1]};
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        state_d   = S_BIT_MARK;
                    end else begin
                        state_d = S_IDLE;
                        error_d = 1'b1;
                    end
                end
            end
            S_REP_MARK: begin
                if (fall) begin
                    state_d = S_IDLE;
                    rep_d   = in_win(dur_q, 8'd1, 8'd3);
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if ((sr_q[15:8] == ~sr_q[7:0]) && (sr_q[31:24] == ~sr_q[23:16])) begin
                    addr_d = sr_q[7:0];
                    cmd_d  = sr_q[23:16];
                    done_d = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            read_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            rep_q     <= 1'b0;
            addr_q    <= '0;
            cmd_q     <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            read_q    <= read_d;
            done_q    <= done_d;
            error_q   <= error_d;
            rep_q     <= rep_d;
            addr_q    <= addr_d;
            cmd_q     <= cmd_d;
        end
    end

    assign read        = read_q;
    assign done        = done_q;
    assign error       = error_q;
    assign repeat_code = rep_q;
    assign address     = addr_q;
    assign command     = cmd_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Self-checking bench for ir_nec_decoder: directed and random NEC frames scored
// against a frame-level reference model of the expected events and outputs.
module tb_ir_nec_decoder;

    localparam int TPU  = 8;
    localparam int TOH  = 40;
    localparam int HALF = TPU / 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       ir_in;
    logic       read, done, error, repeat_code, busy;
    logic [7:0] address, command;

    ir_nec_decoder #(.TICKS_PER_UNIT(TPU), .TIMEOUT_HALF(TOH)) dut (
        .clk(clk), .reset(reset), .ir_in(ir_in),
        .read(read), .done(done), .error(error), .repeat_code(repeat_code),
        .address(address), .command(command), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_read = 0, n_done = 0, n_err = 0, n_rep = 0;
    bit open = 1'b0;
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_cmd  = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Event monitor: counts pulses and enforces read -> done/error pairing.
    always @(negedge clk) begin
        if (reset) begin
            open = 1'b0;
        end else begin
            if (read || done || error || repeat_code)
                check("onehot", $countones({read, done, error, repeat_code}), 1);
            if (read) begin
                check("read_while_open", open, 0);
                open = 1'b1;
                n_read++;
            end
            if (done || error) begin
                check("close_without_read", open, 1);
                open = 1'b0;
            end
            if (done) n_done++;
            if (error) n_err++;
            if (repeat_code) n_rep++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic send_level(input logic lvl, input int h);
        ir_in = lvl;
        repeat (h * HALF) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            send_level(1'b0, 2);
            send_level(1'b1, bits[i] ? 6 : 2);
        end
    endtask

    task automatic frame_case(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int lead_h);
        int r = n_read, d = n_done, e = n_err, p = n_rep;
        logic [7:0] nb0 = ~b0;
        logic [7:0] nb2 = ~b2;
        bit lead_ok = (lead_h >= 28) && (lead_h <= 36);
        bit pass    = (b1 == nb0) && (b3 == nb2);
        send_level(1'b0, lead_h);
        ir_in = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("busy_after_leader", busy, lead_ok);
        repeat (16 * HALF - 6) @(posedge clk);
        #1;
        send_bits({b3, b2, b1, b0}, 32);
        send_level(1'b0, 2);
        send_level(1'b1, 12);
        check("read_count", n_read - r, lead_ok);
        check("done_count", n_done - d, lead_ok && pass);
        check("error_count", n_err - e, lead_ok && !pass);
        check("repeat_count", n_rep - p, 0);
        if (lead_ok && pass) begin
            m_addr = b0;
            m_cmd  = b2;
        end
        check("address", address, m_addr);
        check("command", command, m_cmd);
        check("busy_idle", busy, 0);
    endtask

    task automatic repeat_case(input int space_h);
        int r = n_read, d = n_done, e = n_err, p = n_rep;
        bit rep_ok = (space_h >= 6) && (space_h <= 10);
        send_level(1'b0, 32);
        send_level(1'b1, space_h);
        send_level(1'b0, 2);
        send_level(1'b1, 12);
        check("rep_repeat_count", n_rep - p, rep_ok);
        check("rep_read_count", n_read - r, 0);
        check("rep_done_count", n_done - d, 0);
        check("rep_error_count", n_err - e, 0);
        check("rep_busy", busy, 0);
    endtask

    task automatic timeout_case();
        int r = n_read, e = n_err, d = n_done;
        int first = 0;
        // sync latency 3, then dur passes TIMEOUT after TOH+1 half-units, pulse one cycle later
        int exp_cyc = 3 + (TOH + 1) * HALF + 1;
        send_level(1'b0, 32);
        send_level(1'b1, 16);
        send_bits($urandom, 10);
        send_level(1'b0, 2);
        ir_in = 1'b1;
        for (int c = 1; c <= exp_cyc + 20; c++) begin
            @(posedge clk);
            #1;
            if (error && first == 0) first = c;
            if (c == exp_cyc - 1) check("to_busy_before", busy, 1);
            if (c == exp_cyc + 1) check("to_busy_after", busy, 0);
        end
        check("to_error_cycle", first, exp_cyc);
        check("to_read_count", n_read - r, 1);
        check("to_error_count", n_err - e, 1);
        check("to_done_count", n_done - d, 0);
        check("to_address", address, m_addr);
    endtask

    task automatic reset_case();
        int e = n_err, d = n_done;
        send_level(1'b0, 32);
        send_level(1'b1, 16);
        send_bits(32'h0000_5A5A, 15);
        ir_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        ir_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {read, done, error, repeat_code, busy, address, command}, 0);
        reset = 1'b0;
        m_addr = 8'h00;
        m_cmd  = 8'h00;
        repeat (60) @(posedge clk);
        #1;
        check("reset_no_error", n_err - e, 0);
        check("reset_no_done", n_done - d, 0);
        check("reset_idle", {busy, address, command}, 0);
        frame_case(8'h01, 8'hFE, 8'h80, 8'h7F, 32);
    endtask

    initial begin
        reset = 1'b1;
        ir_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("por_outputs", {read, done, error, repeat_code, busy, address, command}, 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        frame_case(8'h5A, 8'hA5, 8'h3C, 8'hC3, 32);
        frame_case(8'h5A, 8'h00, 8'h3C, 8'hC3, 32);
        repeat_case(9);
        frame_case(8'h11, 8'hEE, 8'h22, 8'hDD, 20);
        timeout_case();
        reset_case();

        for (int i = 0; i < 10; i++) begin
            logic [7:0] b0, b1, b2, b3;
            int kind;
            int leads[5];
            int spaces[4];
            leads  = '{18, 20, 22, 42, 44};
            spaces = '{7, 8, 9, 12};
            kind = int'($urandom_range(0, 3));
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            b3 = 8'($urandom);
            case (kind)
                0: frame_case(b0, ~b0, b2, ~b2, int'($urandom_range(30, 34)));
                1: frame_case(b0, b1, b2, b3, 32);
                2: repeat_case(spaces[$urandom_range(0, 3)]);
                default: frame_case(b0, ~b0, b2, ~b2, leads[$urandom_range(0, 4)]);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
